// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter using double-dabble, one
// bit per clock. It supports signed or unsigned input, sticky overflow and
// optional leading-zero blanking. Its sign and blank codes match the
// seven-segment drivers: 4'hA = minus, 4'hF = blank.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request a conversion (accepted only while ready=1)
//   sgn      treat bin as two's complement (sampled with start)
//   blank    blank leading zero digits with 4'hF (sampled with start)
//   bin      binary value to convert (sampled with start)
//   ready    idle, can accept start
//   valid    one-cycle pulse: bcd/bcd_sgn/ovf updated
//   bcd      result digits, most significant digit in the top nibble
//   bcd_sgn  4'hA when the result is negative, else 4'hF
//   ovf      magnitude exceeded 10^digits-1; bcd holds value mod 10^digits
module bin2bcd_seq #(
  parameter int width  = 16,
  parameter int digits = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sgn,
  input  logic                  blank,
  input  logic [width-1:0]      bin,
  output logic                  ready,
  output logic                  valid,
  output logic [digits*4-1:0]   bcd,
  output logic [3:0]            bcd_sgn,
  output logic                  ovf
);

  localparam int BW = digits * 4;
  localparam int CW = $clog2(width + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [width-1:0] mag_q, mag_d;
  logic             neg_q, neg_d;
  logic             blank_q, blank_d;
  logic [BW-1:0]    work_q, work_d;
  logic             sticky_q, sticky_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [3:0]       bcd_sgn_q, bcd_sgn_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [BW-1:0]    adj;

  // Add 3 to every nibble that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    r = v;
    for (int i = 0; i < digits; i++) begin
      if (v[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Replace zero nibbles above the most significant nonzero nibble with
  // 4'hF. Nibble 0 always shows, so zero displays as a single "0".
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          seen;
    r    = v;
    seen = 1'b0;
    for (int i = digits - 1; i > 0; i--) begin
      if (v[i*4 +: 4] != 4'd0) begin
        seen = 1'b1;
      end else if (!seen) begin
        r[i*4 +: 4] = 4'hF;
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Next-state and datapath logic for the IDLE/SHIFT/FIN sequencer.
  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    blank_d   = blank_q;
    work_d    = work_q;
    sticky_d  = sticky_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    bcd_sgn_d = bcd_sgn_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    adj       = dabble_adj(work_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          neg_d    = sgn & bin[width-1];
          // Two's-complement negate; the most negative value maps onto
          // itself, which read as unsigned is the correct magnitude.
          mag_d    = (sgn & bin[width-1]) ? (~bin + {{(width-1){1'b0}}, 1'b1}) : bin;
          blank_d  = blank;
          work_d   = {BW{1'b0}};
          sticky_d = 1'b0;
          cnt_d    = CW'(width);
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        // A 1 leaving the top nibble means a decimal digit beyond 'digits'.
        sticky_d = sticky_q | adj[BW-1];
        work_d   = {adj[BW-2:0], mag_q[width-1]};
        mag_d    = {mag_q[width-2:0], 1'b0};
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIN;
        end else begin
          state_d = SHIFT;
        end
      end
      FIN: begin
        bcd_d     = blank_q ? blank_lz(work_q) : work_q;
        bcd_sgn_d = neg_q ? 4'hA : 4'hF;
        ovf_d     = sticky_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  // State and output registers; reset forces the idle, cleared condition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_q     <= {width{1'b0}};
      neg_q     <= 1'b0;
      blank_q   <= 1'b0;
      work_q    <= {BW{1'b0}};
      sticky_q  <= 1'b0;
      cnt_q     <= {CW{1'b0}};
      bcd_q     <= {BW{1'b0}};
      bcd_sgn_q <= 4'hF;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      blank_q   <= blank_d;
      work_q    <= work_d;
      sticky_q  <= sticky_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      bcd_sgn_q <= bcd_sgn_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign bcd     = bcd_q;
  assign bcd_sgn = bcd_sgn_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: a 16-bit/5-digit instance and a 16-bit/4-digit
// instance (for overflow). Expected results are queued when a conversion is
// started and compared when valid pulses.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start5, start4;
  logic        sgn, blank;
  logic [15:0] bin;
  logic        ready5, valid5, ready4, valid4;
  logic [19:0] bcd5;
  logic [15:0] bcd4;
  logic [3:0]  bsgn5, bsgn4;
  logic        ovf5, ovf4;

  typedef struct {
    logic [19:0] bcd;
    logic [3:0]  bsgn;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [15:0] bin;
    logic        sgn;
    logic        blank;
    logic [19:0] bcd;
    logic [3:0]  bsgn;
    logic        ovf;
  } vec_t;

  exp_t q5[$];
  exp_t q4[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   nvalid5 = 0;
  int   nvalid4 = 0;
  vec_t tbl[12];

  bin2bcd_seq #(.width(16), .digits(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start5), .sgn(sgn), .blank(blank), .bin(bin),
    .ready(ready5), .valid(valid5), .bcd(bcd5), .bcd_sgn(bsgn5), .ovf(ovf5)
  );

  bin2bcd_seq #(.width(16), .digits(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sgn(sgn), .blank(blank), .bin(bin),
    .ready(ready4), .valid(valid4), .bcd(bcd4), .bcd_sgn(bsgn4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference: magnitude mod 10^nd, decimal digits, blanking.
  function automatic exp_t model(input logic [15:0] b, input logic s, input logic bl, input int nd);
    exp_t        e;
    int unsigned m;
    int unsigned lim;
    logic        neg;
    logic        seen;
    neg  = s & b[15];
    m    = neg ? (32'd65536 - {16'd0, b}) : {16'd0, b};
    lim  = (nd == 4) ? 32'd10000 : 32'd100000;
    e.ovf  = (m >= lim);
    e.bsgn = neg ? 4'hA : 4'hF;
    m    = m % lim;
    e.bcd = 20'd0;
    for (int i = 0; i < nd; i++) begin
      e.bcd[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    seen = 1'b0;
    for (int i = nd - 1; i > 0; i--) begin
      if (e.bcd[i*4 +: 4] != 4'd0) seen = 1'b1;
      else if (bl && !seen) e.bcd[i*4 +: 4] = 4'hF;
    end
    return e;
  endfunction

  // Scoreboard monitor for the 5-digit instance.
  always @(negedge clk) begin
    if (rst_n && valid5) begin
      exp_t e;
      nvalid5++;
      if (q5.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_valid5: got bcd %h, expected no result", bcd5);
      end else begin
        e = q5.pop_front();
        check("bcd5", {12'd0, bcd5}, {12'd0, e.bcd});
        check("bcd_sgn5", {28'd0, bsgn5}, {28'd0, e.bsgn});
        check("ovf5", {31'd0, ovf5}, {31'd0, e.ovf});
      end
    end
  end

  // Scoreboard monitor for the 4-digit instance.
  always @(negedge clk) begin
    if (rst_n && valid4) begin
      exp_t e;
      nvalid4++;
      if (q4.size() == 0) begin
        n_vec++; n_miss++;
        $display("FAIL unexpected_valid4: got bcd %h, expected no result", bcd4);
      end else begin
        e = q4.pop_front();
        check("bcd4", {16'd0, bcd4}, {16'd0, e.bcd[15:0]});
        check("bcd_sgn4", {28'd0, bsgn4}, {28'd0, e.bsgn});
        check("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
      end
    end
  end

  // Wait for ready, start one conversion, queue its expectation and check
  // that valid arrives exactly 17 clocks after the accepting edge.
  task automatic do_conv(input bit use4, input logic [15:0] b, input logic s, input logic bl,
                         input exp_t e);
    int k;
    @(negedge clk);
    for (int i = 0; i < 100 && !(use4 ? ready4 : ready5); i++) @(negedge clk);
    check("ready_before_start", {31'd0, (use4 ? ready4 : ready5)}, 32'd1);
    bin = b; sgn = s; blank = bl;
    if (use4) begin start4 = 1'b1; q4.push_back(e); end
    else      begin start5 = 1'b1; q5.push_back(e); end
    @(posedge clk);
    #1;
    start4 = 1'b0; start5 = 1'b0;
    bin = 16'hDEAD; sgn = ~s; blank = ~bl;
    k = 1;
    while (k < 40) begin
      @(posedge clk);
      #1;
      if (use4 ? valid4 : valid5) break;
      k++;
    end
    check("latency", k, 32'd17);
  endtask

  initial begin
    exp_t e;
    int   k;

    tbl[0]  = '{16'hFFFF, 1'b0, 1'b0, 20'h65535, 4'hF, 1'b0};
    tbl[1]  = '{16'hFFFF, 1'b1, 1'b0, 20'h00001, 4'hA, 1'b0};
    tbl[2]  = '{16'hFFFF, 1'b1, 1'b1, 20'hFFFF1, 4'hA, 1'b0};
    tbl[3]  = '{16'h0000, 1'b0, 1'b1, 20'hFFFF0, 4'hF, 1'b0};
    tbl[4]  = '{16'h8000, 1'b1, 1'b0, 20'h32768, 4'hA, 1'b0};
    tbl[5]  = '{16'h0000, 1'b1, 1'b0, 20'h00000, 4'hF, 1'b0};
    tbl[6]  = '{16'h002A, 1'b0, 1'b1, 20'hFFF42, 4'hF, 1'b0};
    tbl[7]  = '{16'h1000, 1'b0, 1'b1, 20'hF4096, 4'hF, 1'b0};
    tbl[8]  = '{16'hFF9C, 1'b1, 1'b1, 20'hFF100, 4'hA, 1'b0};
    tbl[9]  = '{16'h2710, 1'b0, 1'b1, 20'h10000, 4'hF, 1'b0};
    tbl[10] = '{16'h7FFF, 1'b1, 1'b0, 20'h32767, 4'hF, 1'b0};
    tbl[11] = '{16'h8000, 1'b0, 1'b1, 20'h32768, 4'hF, 1'b0};

    rst_n = 1'b0; start5 = 1'b0; start4 = 1'b0; sgn = 1'b0; blank = 1'b0; bin = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready5}, 32'd1);
    check("rst_valid", {31'd0, valid5}, 32'd0);
    check("rst_bcd", {12'd0, bcd5}, 32'd0);
    check("rst_bcd_sgn", {28'd0, bsgn5}, 32'hF);
    check("rst_ovf", {31'd0, ovf5}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on the 5-digit instance.
    for (int i = 0; i < 12; i++) begin
      e.bcd = tbl[i].bcd; e.bsgn = tbl[i].bsgn; e.ovf = tbl[i].ovf;
      do_conv(1'b0, tbl[i].bin, tbl[i].sgn, tbl[i].blank, e);
    end

    // Outputs hold between valid pulses.
    repeat (4) @(posedge clk);
    #1;
    check("hold_bcd", {12'd0, bcd5}, 32'h32768);
    check("hold_valid", {31'd0, valid5}, 32'd0);

    // Random vectors against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] rb;
      logic        rs, rl;
      rb = 16'($urandom);
      rs = 1'($urandom);
      rl = 1'($urandom);
      do_conv(1'b0, rb, rs, rl, model(rb, rs, rl, 5));
    end

    // Overflow and sticky clear on the 4-digit instance.
    e.bcd = 20'h02345; e.bsgn = 4'hF; e.ovf = 1'b1;
    do_conv(1'b1, 16'd12345, 1'b0, 1'b0, e);
    e.bcd = 20'h09999; e.bsgn = 4'hF; e.ovf = 1'b0;
    do_conv(1'b1, 16'd9999, 1'b0, 1'b0, e);
    e.bcd = 20'h0FFF5; e.bsgn = 4'hF; e.ovf = 1'b1;
    do_conv(1'b1, 16'd10005, 1'b0, 1'b1, e);
    do_conv(1'b1, 16'hFFFF, 1'b1, 1'b0, model(16'hFFFF, 1'b1, 1'b0, 4));

    // Start pulsed mid-conversion is ignored: only 200 comes out.
    @(negedge clk);
    bin = 16'd200; sgn = 1'b0; blank = 1'b0; start5 = 1'b1;
    e.bcd = 20'h00200; e.bsgn = 4'hF; e.ovf = 1'b0;
    q5.push_back(e);
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy_ready", {31'd0, ready5}, 32'd0);
    bin = 16'd100; start5 = 1'b1;
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("ignored_start_queue", q5.size(), 32'd0);

    // Start held from FIN: ignored at the FIN edge, accepted one edge later.
    @(negedge clk);
    bin = 16'd300; start5 = 1'b1;
    e.bcd = 20'h00300;
    q5.push_back(e);
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check("fin_ready", {31'd0, ready5}, 32'd0);
    check("fin_valid", {31'd0, valid5}, 32'd0);
    bin = 16'd7; start5 = 1'b1;
    e.bcd = 20'h00007;
    q5.push_back(e);
    @(posedge clk);
    #1;
    check("post_fin_valid", {31'd0, valid5}, 32'd1);
    check("post_fin_ready", {31'd0, ready5}, 32'd1);
    @(posedge clk);
    #1;
    start5 = 1'b0;
    check("held_start_accepted", {31'd0, ready5}, 32'd0);
    k = 1;
    while (k < 40) begin
      @(posedge clk);
      #1;
      if (valid5) break;
      k++;
    end
    check("held_latency", k, 32'd17);

    // Reset mid-SHIFT aborts without a valid pulse.
    @(negedge clk);
    bin = 16'd12345; start5 = 1'b1;
    e.bcd = 20'h12345;
    q5.push_back(e);
    @(posedge clk);
    #1;
    start5 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    void'(q5.pop_back());
    #1;
    check("abort_ready", {31'd0, ready5}, 32'd1);
    check("abort_valid", {31'd0, valid5}, 32'd0);
    check("abort_bcd", {12'd0, bcd5}, 32'd0);
    check("abort_bcd_sgn", {28'd0, bsgn5}, 32'hF);
    check("abort_ovf", {31'd0, ovf5}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_valid", {31'd0, valid5}, 32'd0);
    e.bcd = 20'h00042;
    do_conv(1'b0, 16'd42, 1'b0, 1'b0, e);

    // Drain and confirm every expected result arrived.
    repeat (5) @(posedge clk);
    check("q5_empty", q5.size(), 32'd0);
    check("q4_empty", q4.size(), 32'd0);
    check("valid5_count", nvalid5, 32'd24);
    check("valid4_count", nvalid4, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
